// File: rtl/qam_mapper.sv
// Serial-bit to BPSK/QPSK/16QAM constellation mapper with handshakes.
// Define QAM16_GRAY_EN for Gray-coded 16QAM axes (natural order otherwise).
module qam_mapper #(
   parameter int OUT_W  = 16,
   parameter int FRAC_W = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              mode,
   input  logic                    in_valid,
   input  logic                    in_bit,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_i,
   output logic signed [OUT_W-1:0] out_q
);

   // Rounded sqrt(num/den): largest n with (n-1/2)^2 <= num/den.
   function automatic int rnd_sqrt(input longint num, input longint den);
      longint n;
      n = 0;
      while (den * (4 * (n + 1) * (n + 1) - 4 * (n + 1) + 1) <= 4 * num)
         n = n + 1;
      return int'(n);
   endfunction

   localparam longint P2 = longint'(1) << (2 * FRAC_W);

   localparam logic signed [OUT_W-1:0] A1 = OUT_W'(1 << FRAC_W);
   localparam logic signed [OUT_W-1:0] AQ = OUT_W'(rnd_sqrt(P2, 2));
   localparam logic signed [OUT_W-1:0] L1 = OUT_W'(rnd_sqrt(P2, 10));
   localparam logic signed [OUT_W-1:0] L3 = OUT_W'(rnd_sqrt(9 * P2, 10));

   localparam logic [1:0] M_BPSK  = 2'd0;
   localparam logic [1:0] M_QPSK  = 2'd1;
   localparam logic [1:0] M_QAM16 = 2'd2;

   function automatic logic signed [OUT_W-1:0] lvl16(input logic [1:0] p);
      logic signed [OUT_W-1:0] v;
`ifdef QAM16_GRAY_EN
      case (p)
         2'b01:   v = L3;
         2'b00:   v = L1;
         2'b10:   v = -L1;
         default: v = -L3;
      endcase
`else
      case (p)
         2'b00:   v = L3;
         2'b01:   v = L1;
         2'b10:   v = -L1;
         default: v = -L3;
      endcase
`endif
      return v;
   endfunction

   logic [1:0] cnt;
   logic [2:0] sh;
   logic [1:0] mode_l;
   logic [1:0] eff;
   logic [1:0] kl;
   logic [3:0] bits;
   logic       last;
   logic       take_bit;
   logic       take_sym;
   logic signed [OUT_W-1:0] ni;
   logic signed [OUT_W-1:0] nq;

   // Mode is only honoured at the start of a symbol.
   assign eff  = (cnt == 2'd0) ? mode : mode_l;
   assign bits = {sh, in_bit};

   always_comb begin
      kl = 2'd1;
      ni = '0;
      nq = '0;
      unique case (1'b1)
         (eff == M_BPSK): begin
            kl = 2'd0;
            ni = in_bit ? -A1 : A1;
            nq = '0;
         end
         (eff == M_QAM16): begin
            kl = 2'd3;
            nq = lvl16(bits[3:2]);
            ni = lvl16(bits[1:0]);
         end
         default: begin
            kl = 2'd1;
            nq = bits[1] ? -AQ : AQ;
            ni = bits[0] ? -AQ : AQ;
         end
      endcase
   end

   assign last     = (cnt == kl);
   assign in_ready = !(last && out_valid && !out_ready);
   assign take_bit = in_valid && in_ready;
   assign take_sym = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         sh        <= '0;
         mode_l    <= M_QPSK;
         out_valid <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
      end else if (take_bit && last) begin
         cnt       <= '0;
         out_i     <= ni;
         out_q     <= nq;
         out_valid <= 1'b1;
      end else begin
         if (take_bit) begin
            cnt <= cnt + 2'd1;
            sh  <= {sh[1:0], in_bit};
            if (cnt == 2'd0)
               mode_l <= mode;
         end
         if (take_sym)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_qam_mapper.sv
// Self-checking bench for qam_mapper: spec-level model plus directed vectors.
module tb_qam_mapper;

   localparam int OUT_W  = 16;
   localparam int FRAC_W = 7;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] mode;
   logic in_valid;
   logic in_bit;
   logic in_ready;
   logic out_valid;
   logic out_ready;
   logic signed [OUT_W-1:0] out_i;
   logic signed [OUT_W-1:0] out_q;

   qam_mapper #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
      .clk(clk),
      .rst(rst),
      .mode(mode),
      .in_valid(in_valid),
      .in_bit(in_bit),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_i(out_i),
      .out_q(out_q)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit en = 0;

   int a1, aq, l1, l3;

   int m_cnt, m_acc, m_mode, m_i, m_q;
   bit m_valid;

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   function automatic int bits_per(input int md);
      if (md == 0) return 1;
      if (md == 2) return 4;
      return 2;
   endfunction

   function automatic int cur_mode();
      return (m_cnt == 0) ? int'(mode) : m_mode;
   endfunction

   function automatic bit exp_ready();
      int k;
      k = bits_per(cur_mode());
      return !(m_cnt == k - 1 && m_valid && !out_ready);
   endfunction

   function automatic int axis(input int p);
`ifdef QAM16_GRAY_EN
      case (p)
         1: return l3;
         0: return l1;
         2: return -l1;
         default: return -l3;
      endcase
`else
      case (p)
         0: return l3;
         1: return l1;
         2: return -l1;
         default: return -l3;
      endcase
`endif
   endfunction

   // Model: collect bits as an integer, map once k bits are in.
   always @(posedge clk) begin : model
      int md;
      int k;
      bit rdy;
      bit tsym;
      if (rst) begin
         m_cnt = 0; m_acc = 0; m_mode = 1;
         m_valid = 0; m_i = 0; m_q = 0;
      end else begin
         md   = cur_mode();
         k    = bits_per(md);
         rdy  = exp_ready();
         tsym = m_valid && out_ready;
         if (in_valid && rdy) begin
            if (m_cnt == 0) m_mode = int'(mode);
            m_acc = m_acc * 2 + int'(in_bit);
            m_cnt++;
            if (m_cnt == k) begin
               case (k)
                  1: begin
                     m_i = m_acc ? -a1 : a1;
                     m_q = 0;
                  end
                  4: begin
                     m_q = axis(m_acc / 4);
                     m_i = axis(m_acc % 4);
                  end
                  default: begin
                     m_q = (m_acc / 2) ? -aq : aq;
                     m_i = (m_acc % 2) ? -aq : aq;
                  end
               endcase
               m_valid = 1;
               m_cnt = 0;
               m_acc = 0;
            end else if (tsym) begin
               m_valid = 0;
            end
         end else if (tsym) begin
            m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("out_valid", int'(out_valid), int'(m_valid));
         chk("in_ready", int'(in_ready), int'(exp_ready()));
         if (m_valid) begin
            chk("out_i", int'(out_i), m_i);
            chk("out_q", int'(out_q), m_q);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic bitin(input logic b);
      in_valid = 1'b1;
      in_bit   = b;
      cyc();
   endtask

   initial begin
      a1 = 1 << FRAC_W;
      aq = $rtoi(a1 / $sqrt(2.0) + 0.5);
      l1 = $rtoi(a1 / $sqrt(10.0) + 0.5);
      l3 = $rtoi(3.0 * a1 / $sqrt(10.0) + 0.5);

      rst = 1; mode = 2'd1; in_valid = 0; in_bit = 0; out_ready = 1;
      cyc();
      en = 1;
      cyc();
      rst = 0;
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_i", int'(out_i), 0);
      chk("rst_q", int'(out_q), 0);
      chk("rst_ready", int'(in_ready), 1);

      // QPSK 0,1
      mode = 2'd1;
      bitin(0);
      bitin(1);
      in_valid = 0;
      chk("qpsk_v", int'(out_valid), 1);
      chk("qpsk_i", int'(out_i), -91);
      chk("qpsk_q", int'(out_q), 91);

      // BPSK 1,0,1 back to back
      mode = 2'd0;
      bitin(1);
      chk("bpsk0_v", int'(out_valid), 1);
      chk("bpsk0_i", int'(out_i), -128);
      bitin(0);
      chk("bpsk1_v", int'(out_valid), 1);
      chk("bpsk1_i", int'(out_i), 128);
      bitin(1);
      chk("bpsk2_v", int'(out_valid), 1);
      chk("bpsk2_i", int'(out_i), -128);
      chk("bpsk2_q", int'(out_q), 0);
      in_valid = 0;
      cyc();
      chk("bpsk_drain", int'(out_valid), 0);

      // 16QAM 0,1,1,1
      mode = 2'd2;
      bitin(0); bitin(1); bitin(1); bitin(1);
      in_valid = 0;
      chk("qam_v", int'(out_valid), 1);
      chk("qam_i", int'(out_i), -121);
`ifdef QAM16_GRAY_EN
      chk("qam_q", int'(out_q), 121);
`else
      chk("qam_q", int'(out_q), 40);
`endif
      cyc();

      // Backpressure on QPSK
      mode = 2'd1;
      bitin(1);
      bitin(1);
      out_ready = 0;
      bitin(0);
      chk("bp_v", int'(out_valid), 1);
      chk("bp_i", int'(out_i), -91);
      chk("bp_q", int'(out_q), -91);
      in_valid = 1; in_bit = 1;
      #1;
      chk("bp_rdy0", int'(in_ready), 0);
      cyc();
      chk("bp_hold_i", int'(out_i), -91);
      chk("bp_hold_q", int'(out_q), -91);
      chk("bp_rdy1", int'(in_ready), 0);
      out_ready = 1;
      #1;
      chk("bp_rdy2", int'(in_ready), 1);
      cyc();
      chk("bp_new_v", int'(out_valid), 1);
      chk("bp_new_i", int'(out_i), -91);
      chk("bp_new_q", int'(out_q), 91);
      in_valid = 0;
      cyc();
      chk("bp_drain", int'(out_valid), 0);

      // Reset mid-symbol
      mode = 2'd2;
      bitin(1);
      bitin(0);
      in_valid = 0;
      mode = 2'd0;
      rst = 1;
      cyc();
      rst = 0;
      chk("mid_rst_v", int'(out_valid), 0);
      cyc();
      chk("mid_rst_v2", int'(out_valid), 0);
      bitin(1);
      chk("post_rst_v", int'(out_valid), 1);
      chk("post_rst_i", int'(out_i), -128);
      chk("post_rst_q", int'(out_q), 0);
      in_valid = 0;
      cyc();

      // Sustained QPSK stream, no stalls
      mode = 2'd1;
      out_ready = 1;
      for (int n = 0; n < 16; n++) bitin(1'(n % 3 == 0));
      in_valid = 0;
      cyc();

      // Mixed traffic checked by the model
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(0, 9) < 8);
         in_bit    = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
         rst = ($urandom_range(0, 99) == 0);
         cyc();
      end
      rst = 0; in_valid = 0; out_ready = 1;
      cyc();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
